pc_flow_monitor: RTL and testbench
==================================

Name: pc_flow_monitor

Overview:
- Runtime integrity checker for the instruction-fetch path. It watches the committed fetch stream (PC plus instruction byte) and checks that every fetch address equals previous PC + 1, unless the core has flagged a legitimate redirect.
- Detects silent PC skips of the kind injected by a tampered next-PC path, such as +2 skips keyed on specific opcode nibbles.
- Captures details of the first violation, counts all violations and raises a sticky alarm when violations cluster within a fetch window.
- Sits beside the fetch unit as a passive observer and never drives the PC.

Parameters:
- ALARM_THRESH, 2: number of mismatches inside one window that triggers the alarm (legal range 1..WINDOW).
- WINDOW, 16: window length, in compared fetches.
- CNT_W, 8: width of the total mismatch counter.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous reset, active-high.
- fetch_valid  input  1  a fetch is committed this cycle.
- fetch_pc  input  16  address of the committed fetch.
- fetch_instr  input  8  instruction byte at fetch_pc; opcode = fetch_instr[7:4].
- redirect  input  1  legitimate discontinuity (branch, jump, interrupt); exempts the next committed fetch.
- clear_alarm  input  1  clears the alarm, the window counters and the capture registers.
- alarm  output  1  sticky violation alarm.
- mismatch_pulse  output  1  one-cycle pulse for each detected mismatch.
- mismatch_count  output  CNT_W  total mismatches since reset; saturates.
- cap_valid  output  1  the capture registers hold a first-violation record.
- cap_pc  output  16  fetch_pc of the first offending fetch.
- cap_expected  output  16  expected address at the first offending fetch.
- cap_opcode  output  4  opcode of the instruction that preceded the first offending fetch.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE.
  - All outputs become 0: alarm, mismatch_pulse, mismatch_count, cap_valid, cap_pc, cap_expected, cap_opcode.
  - Internal state prev_pc, prev_op, pending_redir, win_fetch and win_miss becomes 0.
  - Reset has priority over every other input, including reset asserted in the middle of ALARM.
- FSM states: IDLE, TRACK, ALARM.
  - IDLE: no reference PC exists yet. The first fetch_valid loads prev_pc and prev_op, does no compare, and moves to TRACK.
  - TRACK / ALARM: every fetch_valid is either compared or exempted (rules below), then updates prev_pc to fetch_pc and prev_op to fetch_instr[7:4].
- Expected address: expected = prev_pc + 1, modulo 2^16, so 0xFFFF is followed by 0x0000.
- Exemption:
  - A fetch is exempt if redirect=1 in the same cycle, or if pending_redir=1.
  - redirect=1 with fetch_valid=0 sets pending_redir.
  - Any fetch_valid clears pending_redir.
  - Exempt fetches do not increment win_fetch.
- Compare (non-exempt fetch_valid in TRACK or ALARM):
  - Mismatch when fetch_pc != expected.
  - On a mismatch:
    - mismatch_pulse is 1 in the following cycle.
    - mismatch_count increments, saturating at 2^CNT_W-1.
    - win_miss increments.
  - If cap_valid=0, the same edge latches cap_pc=fetch_pc, cap_expected=expected, cap_opcode=prev_op and cap_valid=1. Later mismatches never overwrite the capture until the next clear or reset.
- Window:
  - win_fetch counts compared fetches.
  - The alarm check uses win_miss including the current fetch.
  - If that check reaches ALARM_THRESH while in TRACK, the FSM moves to ALARM and alarm=1 from the next cycle.
  - When win_fetch reaches WINDOW on a fetch, win_fetch and win_miss reset to 0 after that fetch is evaluated.
- ALARM state:
  - alarm holds at 1.
  - Tracking, counting and pulses continue.
- clear_alarm (when rst=0):
  - In ALARM, moves the FSM to TRACK; in IDLE or TRACK, the state is unchanged.
  - Sets alarm=0, win_fetch=0, win_miss=0 and cap_valid=0.
  - Leaves mismatch_count, prev_pc and prev_op unchanged.
  - If fetch_valid is in the same cycle, the fetch is still evaluated against prev_pc, but the clear wins for alarm and window state. It may still pulse, count and capture.
- Latency: every output is registered and reflects a fetch sampled at edge N at edge N+1. There is no combinational path from inputs to outputs.
- Cycles with fetch_valid=0 change nothing except pending_redir.

Test Plan:
- Sequential stream: rst, then fetches 0x0010, 0x0011, 0x0012 with instr 0x12 -> mismatch_pulse never 1, mismatch_count=0, alarm=0.
- Single skip: fetch 0x0020 with instr 0xD3, then fetch 0x0023 -> next cycle mismatch_pulse=1, mismatch_count=1, cap_valid=1, cap_pc=0x0023, cap_expected=0x0021, cap_opcode=0xD, alarm=0.
- Redirect:
  - redirect pulse with fetch_valid=0, then fetch 0x0400 after 0x0030 -> no mismatch.
  - redirect in the same cycle as a fetch -> that fetch is exempt.
- Alarm and window:
  - Two skips 5 fetches apart (default parameters) -> alarm=1 one cycle after the second skip; alarm stays 1 through further clean fetches.
  - Two skips 20 compared fetches apart -> alarm stays 0 and mismatch_count=2.
- Wrap and clear: fetch 0xFFFF then 0x0000 -> no mismatch. In ALARM, clear_alarm -> alarm=0 and cap_valid=0 next cycle, mismatch_count unchanged.
- Reset mid-operation and saturation:
  - With CNT_W=2, four skips -> mismatch_count=3.
  - rst asserted in ALARM -> all outputs 0 next cycle; the first post-reset fetch is never flagged.

Source files
------------

// File: rtl/pc_flow_monitor.sv
// Passive fetch-stream checker: flags committed fetches whose address is not previous PC + 1
// unless a redirect exempts them, records the first violation and alarms on clustered skips.
module pc_flow_monitor #(
  parameter int ALARM_THRESH = 2,
  parameter int WINDOW       = 16,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  input  logic [15:0]      fetch_pc,
  input  logic [7:0]       fetch_instr,
  input  logic             redirect,
  input  logic             clear_alarm,
  output logic             alarm,
  output logic             mismatch_pulse,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             cap_valid,
  output logic [15:0]      cap_pc,
  output logic [15:0]      cap_expected,
  output logic [3:0]       cap_opcode
);

  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam logic [WIN_W-1:0] WINDOW_V = WIN_W'(WINDOW);
  localparam logic [WIN_W-1:0] THRESH_V = WIN_W'(ALARM_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, TRACK, ALARM} state_t;

  state_t           state_reg;
  logic [15:0]      prev_pc_reg;
  logic [3:0]       prev_op_reg;
  logic             pending_redir_reg;
  logic [WIN_W-1:0] win_fetch_reg;
  logic [WIN_W-1:0] win_miss_reg;
  logic             alarm_reg;
  logic             pulse_reg;
  logic [CNT_W-1:0] count_reg;
  logic             cap_valid_reg;
  logic [15:0]      cap_pc_reg;
  logic [15:0]      cap_expected_reg;
  logic [3:0]       cap_opcode_reg;

  logic [15:0]      expected_next;
  logic             exempt_next;
  logic             compare_next;
  logic             mismatch_next;
  logic [WIN_W-1:0] win_fetch_next;
  logic [WIN_W-1:0] win_miss_next;
  logic             window_full_next;
  logic             thresh_hit_next;

  // Evaluation of the fetch presented this cycle; 16-bit add wraps 0xFFFF to 0x0000.
  always_comb begin
    expected_next    = prev_pc_reg + 16'd1;
    exempt_next      = redirect | pending_redir_reg;
    compare_next     = fetch_valid && (state_reg != IDLE) && !exempt_next;
    mismatch_next    = compare_next && (fetch_pc != expected_next);
    win_fetch_next   = win_fetch_reg + WIN_W'(1);
    win_miss_next    = win_miss_reg + WIN_W'(mismatch_next);
    window_full_next = compare_next && (win_fetch_next >= WINDOW_V);
    thresh_hit_next  = compare_next && (win_miss_next >= THRESH_V);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      prev_pc_reg       <= '0;
      prev_op_reg       <= '0;
      pending_redir_reg <= 1'b0;
      win_fetch_reg     <= '0;
      win_miss_reg      <= '0;
      alarm_reg         <= 1'b0;
      pulse_reg         <= 1'b0;
      count_reg         <= '0;
      cap_valid_reg     <= 1'b0;
      cap_pc_reg        <= '0;
      cap_expected_reg  <= '0;
      cap_opcode_reg    <= '0;
    end else begin
      pulse_reg <= mismatch_next;

      if (mismatch_next && (count_reg != CNT_MAX)) begin
        count_reg <= count_reg + CNT_W'(1);
      end

      // Reference PC follows every committed fetch, exempt or not.
      if (fetch_valid) begin
        prev_pc_reg       <= fetch_pc;
        prev_op_reg       <= fetch_instr[7:4];
        pending_redir_reg <= 1'b0;
      end else if (redirect) begin
        pending_redir_reg <= 1'b1;
      end

      // State and alarm move together so alarm is a registered image of ALARM.
      case (state_reg)
        IDLE: begin
          alarm_reg <= 1'b0;
          if (fetch_valid) begin
            state_reg <= TRACK;
          end
        end
        TRACK: begin
          if (!clear_alarm && thresh_hit_next) begin
            state_reg <= ALARM;
            alarm_reg <= 1'b1;
          end else begin
            alarm_reg <= 1'b0;
          end
        end
        ALARM: begin
          if (clear_alarm) begin
            state_reg <= TRACK;
            alarm_reg <= 1'b0;
          end else begin
            alarm_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          alarm_reg <= 1'b0;
        end
      endcase

      // The clear overrides any window progress made by a same-cycle fetch.
      if (clear_alarm || window_full_next) begin
        win_fetch_reg <= '0;
        win_miss_reg  <= '0;
      end else if (compare_next) begin
        win_fetch_reg <= win_fetch_next;
        win_miss_reg  <= win_miss_next;
      end

      // A mismatch arriving with a clear becomes the new first-violation record.
      if (mismatch_next && (!cap_valid_reg || clear_alarm)) begin
        cap_valid_reg    <= 1'b1;
        cap_pc_reg       <= fetch_pc;
        cap_expected_reg <= expected_next;
        cap_opcode_reg   <= prev_op_reg;
      end else if (clear_alarm) begin
        cap_valid_reg    <= 1'b0;
        cap_pc_reg       <= '0;
        cap_expected_reg <= '0;
        cap_opcode_reg   <= '0;
      end
    end
  end

  assign alarm          = alarm_reg;
  assign mismatch_pulse = pulse_reg;
  assign mismatch_count = count_reg;
  assign cap_valid      = cap_valid_reg;
  assign cap_pc         = cap_pc_reg;
  assign cap_expected   = cap_expected_reg;
  assign cap_opcode     = cap_opcode_reg;

endmodule

// File: tb/tb_pc_flow_monitor.sv
// Directed bench for pc_flow_monitor: a default instance plus a CNT_W=2 instance on the
// same stimulus to exercise counter saturation.
module tb_pc_flow_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [15:0] fetch_pc = '0;
  logic [7:0]  fetch_instr = '0;
  logic        redirect = 1'b0;
  logic        clear_alarm = 1'b0;

  logic        alarm, mismatch_pulse, cap_valid;
  logic [7:0]  mismatch_count;
  logic [15:0] cap_pc, cap_expected;
  logic [3:0]  cap_opcode;

  logic        alarm2, pulse2, cap_valid2;
  logic [1:0]  count2;
  logic [15:0] cap_pc2, cap_expected2;
  logic [3:0]  cap_opcode2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_flow_monitor #(.ALARM_THRESH(2), .WINDOW(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr), .redirect(redirect), .clear_alarm(clear_alarm),
    .alarm(alarm), .mismatch_pulse(mismatch_pulse), .mismatch_count(mismatch_count),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_expected(cap_expected),
    .cap_opcode(cap_opcode)
  );

  pc_flow_monitor #(.ALARM_THRESH(2), .WINDOW(16), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr), .redirect(redirect), .clear_alarm(clear_alarm),
    .alarm(alarm2), .mismatch_pulse(pulse2), .mismatch_count(count2),
    .cap_valid(cap_valid2), .cap_pc(cap_pc2), .cap_expected(cap_expected2),
    .cap_opcode(cap_opcode2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs applied at the falling edge, outputs sampled 1 time unit after the rising edge.
  task automatic step(input logic fv, input logic [15:0] pc, input logic [7:0] ins,
                      input logic rd, input logic clr);
    @(negedge clk);
    fetch_valid = fv;
    fetch_pc    = pc;
    fetch_instr = ins;
    redirect    = rd;
    clear_alarm = clr;
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
    redirect    = 1'b0;
    clear_alarm = 1'b0;
    $display("step fv=%0b pc=%04h instr=%02h rd=%0b clr=%0b rst=%0b -> pulse=%0b cnt=%0d alarm=%0b cap_v=%0b",
             fv, pc, ins, rd, clr, rst, mismatch_pulse, mismatch_count, alarm, cap_valid);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alarm"}, 16'(alarm), 16'h0);
    chk({tag, "_pulse"}, 16'(mismatch_pulse), 16'h0);
    chk({tag, "_count"}, 16'(mismatch_count), 16'h0);
    chk({tag, "_cap_valid"}, 16'(cap_valid), 16'h0);
    chk({tag, "_cap_pc"}, cap_pc, 16'h0);
    chk({tag, "_cap_expected"}, cap_expected, 16'h0);
    chk({tag, "_cap_opcode"}, 16'(cap_opcode), 16'h0);
    chk({tag, "_sat_count"}, 16'(count2), 16'h0);
    chk({tag, "_sat_alarm"}, 16'(alarm2), 16'h0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    step(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    chk_all_zero("reset");

    // Sequential stream: 0x10 loads the reference, 0x11/0x12 are compared (win_fetch=2)
    step(1'b1, 16'h0010, 8'h12, 1'b0, 1'b0);
    chk("seq0_pulse", 16'(mismatch_pulse), 16'h0);
    step(1'b1, 16'h0011, 8'h12, 1'b0, 1'b0);
    chk("seq1_pulse", 16'(mismatch_pulse), 16'h0);
    step(1'b1, 16'h0012, 8'h12, 1'b0, 1'b0);
    chk("seq2_pulse", 16'(mismatch_pulse), 16'h0);
    chk("seq_count", 16'(mismatch_count), 16'h0);
    chk("seq_alarm", 16'(alarm), 16'h0);

    // Single skip: 0x20 (redirected, opcode D) then 0x23 instead of 0x21 (win_fetch=3, miss=1)
    step(1'b1, 16'h0020, 8'hD3, 1'b1, 1'b0);
    chk("skip_redir_pulse", 16'(mismatch_pulse), 16'h0);
    step(1'b1, 16'h0023, 8'h12, 1'b0, 1'b0);
    chk("skip_pulse", 16'(mismatch_pulse), 16'h1);
    chk("skip_count", 16'(mismatch_count), 16'h1);
    chk("skip_cap_valid", 16'(cap_valid), 16'h1);
    chk("skip_cap_pc", cap_pc, 16'h0023);
    chk("skip_cap_expected", cap_expected, 16'h0021);
    chk("skip_cap_opcode", 16'(cap_opcode), 16'hD);
    chk("skip_alarm", 16'(alarm), 16'h0);
    step(1'b1, 16'h0024, 8'h12, 1'b0, 1'b0);       // compared #4
    chk("skip_after_pulse", 16'(mismatch_pulse), 16'h0);

    // Redirect cases (exempt fetches do not advance the window)
    step(1'b1, 16'h0030, 8'h12, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);       // pending redirect
    step(1'b1, 16'h0400, 8'h12, 1'b0, 1'b0);
    chk("pending_redir_pulse", 16'(mismatch_pulse), 16'h0);
    chk("pending_redir_count", 16'(mismatch_count), 16'h1);
    step(1'b1, 16'h0401, 8'h12, 1'b0, 1'b0);       // compared #5
    step(1'b1, 16'h0800, 8'h12, 1'b1, 1'b0);
    chk("same_cycle_redir_pulse", 16'(mismatch_pulse), 16'h0);
    chk("same_cycle_redir_count", 16'(mismatch_count), 16'h1);

    // 16 clean fetches 0x801..0x810 (compared #6..#21); window rolls over at #16
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 16'h0801 + 16'(i), 8'h12, 1'b0, 1'b0);
    end
    chk("clean_run_count", 16'(mismatch_count), 16'h1);
    step(1'b1, 16'h0811, 8'h12, 1'b0, 1'b0);       // compared #22
    // compared #23: skip 20 compared fetches after the first -> new window, no alarm
    step(1'b1, 16'h0813, 8'h12, 1'b0, 1'b0);
    chk("far_skip_pulse", 16'(mismatch_pulse), 16'h1);
    chk("far_skip_count", 16'(mismatch_count), 16'h2);
    chk("far_skip_alarm", 16'(alarm), 16'h0);
    chk("far_skip_cap_pc_kept", cap_pc, 16'h0023);

    // Second skip 5 compared fetches later, same window -> alarm
    step(1'b1, 16'h0814, 8'h12, 1'b0, 1'b0);
    step(1'b1, 16'h0815, 8'h12, 1'b0, 1'b0);
    step(1'b1, 16'h0816, 8'h12, 1'b0, 1'b0);
    step(1'b1, 16'h0817, 8'h12, 1'b0, 1'b0);
    chk("pre_alarm", 16'(alarm), 16'h0);
    step(1'b1, 16'h0820, 8'h12, 1'b0, 1'b0);
    chk("near_skip_pulse", 16'(mismatch_pulse), 16'h1);
    chk("near_skip_alarm", 16'(alarm), 16'h1);
    chk("near_skip_count", 16'(mismatch_count), 16'h3);
    chk("sat_count_3", 16'(count2), 16'h3);
    step(1'b1, 16'h0821, 8'h12, 1'b0, 1'b0);
    chk("alarm_hold1", 16'(alarm), 16'h1);
    chk("alarm_hold1_pulse", 16'(mismatch_pulse), 16'h0);
    step(1'b1, 16'h0822, 8'h12, 1'b0, 1'b0);
    chk("alarm_hold2", 16'(alarm), 16'h1);

    // Fourth skip: 8-bit counter reaches 4, 2-bit counter stays saturated
    step(1'b1, 16'h0830, 8'h12, 1'b0, 1'b0);
    chk("fourth_pulse", 16'(mismatch_pulse), 16'h1);
    chk("fourth_count", 16'(mismatch_count), 16'h4);
    chk("sat_count_hold", 16'(count2), 16'h3);
    chk("fourth_alarm", 16'(alarm), 16'h1);

    // Address wrap
    step(1'b1, 16'hFFFF, 8'h12, 1'b1, 1'b0);
    step(1'b1, 16'h0000, 8'h12, 1'b0, 1'b0);
    chk("wrap_pulse", 16'(mismatch_pulse), 16'h0);
    chk("wrap_count", 16'(mismatch_count), 16'h4);

    // Clear in ALARM
    step(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1);
    chk("clear_alarm", 16'(alarm), 16'h0);
    chk("clear_cap_valid", 16'(cap_valid), 16'h0);
    chk("clear_count_kept", 16'(mismatch_count), 16'h4);
    chk("clear_sat_count_kept", 16'(count2), 16'h3);
    step(1'b1, 16'h0001, 8'h12, 1'b0, 1'b0);       // prev_pc kept across clear
    chk("post_clear_pulse", 16'(mismatch_pulse), 16'h0);
    chk("post_clear_alarm", 16'(alarm), 16'h0);

    // Re-enter ALARM with two skips, then reset mid-ALARM
    step(1'b1, 16'h0005, 8'h12, 1'b0, 1'b0);
    chk("realarm_first_alarm", 16'(alarm), 16'h0);
    chk("realarm_cap_pc", cap_pc, 16'h0005);
    step(1'b1, 16'h0009, 8'h12, 1'b0, 1'b0);
    chk("realarm_alarm", 16'(alarm), 16'h1);
    chk("realarm_count", 16'(mismatch_count), 16'h6);
    rst = 1'b1;
    step(1'b1, 16'h1234, 8'h12, 1'b0, 1'b0);
    rst = 1'b0;
    chk_all_zero("mid_rst");

    // First post-reset fetch only loads the reference
    step(1'b1, 16'h5000, 8'h12, 1'b0, 1'b0);
    chk("post_rst_first_pulse", 16'(mismatch_pulse), 16'h0);
    chk("post_rst_first_count", 16'(mismatch_count), 16'h0);
    step(1'b1, 16'h5001, 8'hA7, 1'b0, 1'b0);
    chk("post_rst_seq_pulse", 16'(mismatch_pulse), 16'h0);
    step(1'b1, 16'h5003, 8'h12, 1'b0, 1'b0);
    chk("post_rst_skip_pulse", 16'(mismatch_pulse), 16'h1);
    chk("post_rst_skip_count", 16'(mismatch_count), 16'h1);
    chk("post_rst_cap_expected", cap_expected, 16'h5002);
    chk("post_rst_cap_opcode", 16'(cap_opcode), 16'hA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
